// File: rtl/riscv_bus_master.sv
// Core load/store port to AHB-Lite single-transfer master.
// Handles sizing, lane steering, load extension, wait states, bus errors, timeout and misalignment.
module riscv_bus_master #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic [ADDR_W-1:0] haddr_o,
    output logic [1:0]        htrans_o,
    output logic              hwrite_o,
    output logic [2:0]        hsize_o,
    output logic [DATA_W-1:0] hwdata_o,
    input  logic [DATA_W-1:0] hrdata_i,
    input  logic              hready_i,
    input  logic              hresp_i
);

    localparam int unsigned LANES = DATA_W / 8;
    localparam int unsigned LB    = $clog2(LANES);
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic             TO_EN    = (TIMEOUT != 0);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ADDR  = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] haddr_q, haddr_d;
    logic [1:0]        htrans_q, htrans_d;
    logic              hwrite_q, hwrite_d;
    logic [2:0]        hsize_q, hsize_d;
    logic [DATA_W-1:0] hwdata_q, hwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              unsigned_q, unsigned_d;

    logic              req_legal;
    logic [DATA_W-1:0] wdata_rep;
    logic [DATA_W-1:0] rd_shift;
    logic [DATA_W-1:0] rd_keep;
    logic              rd_sign;
    logic [DATA_W-1:0] load_data;
    logic              timed_out;

    assign req_ready_o = (state_q == S_IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign haddr_o     = haddr_q;
    assign htrans_o    = htrans_q;
    assign hwrite_o    = hwrite_q;
    assign hsize_o     = hsize_q;
    assign hwdata_o    = hwdata_q;

    // Alignment / legality of the incoming request and store-lane replication
    always_comb begin
        case (req_size_i)
            2'd0:    req_legal = 1'b1;
            2'd1:    req_legal = ~req_addr_i[0];
            2'd2:    req_legal = (req_addr_i[1:0] == 2'b00);
            default: req_legal = (DATA_W == 64) && (req_addr_i[2:0] == 3'b000);
        endcase
        case (req_size_i)
            2'd0:    wdata_rep = {LANES{req_wdata_i[7:0]}};
            2'd1:    wdata_rep = {(LANES / 2){req_wdata_i[15:0]}};
            2'd2:    wdata_rep = {(LANES / 4){req_wdata_i[31:0]}};
            default: wdata_rep = req_wdata_i;
        endcase
    end

    // Load steering: shift the addressed lane down, then sign- or zero-extend
    always_comb begin
        rd_shift = hrdata_i >> {haddr_q[LB-1:0], 3'b000};
        case (hsize_q[1:0])
            2'd0: begin
                rd_keep = DATA_W'({8{1'b1}});
                rd_sign = rd_shift[7];
            end
            2'd1: begin
                rd_keep = DATA_W'({16{1'b1}});
                rd_sign = rd_shift[15];
            end
            2'd2: begin
                rd_keep = DATA_W'({32{1'b1}});
                rd_sign = rd_shift[31];
            end
            default: begin
                rd_keep = '1;
                rd_sign = rd_shift[DATA_W-1];
            end
        endcase
        load_data = (rd_shift & rd_keep) | ((rd_sign && !unsigned_q) ? ~rd_keep : '0);
    end

    assign timed_out = TO_EN && (cnt_q == TO_LIMIT);

    always_comb begin
        state_d     = state_q;
        haddr_d     = haddr_q;
        htrans_d    = htrans_q;
        hwrite_d    = hwrite_q;
        hsize_d     = hsize_q;
        hwdata_d    = hwdata_q;
        cnt_d       = cnt_q;
        unsigned_d  = unsigned_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    cnt_d      = '0;
                    unsigned_d = req_unsigned_i;
                    if (req_legal) begin
                        state_d  = S_ADDR;
                        htrans_d = HT_NONSEQ;
                        haddr_d  = req_addr_i;
                        hwrite_d = req_write_i;
                        hsize_d  = {1'b0, req_size_i};
                        if (req_write_i) begin
                            hwdata_d = wdata_rep;
                        end
                    end else begin
                        state_d = S_FAULT;
                    end
                end
            end
            S_ADDR, S_DATA: begin
                if (timed_out) begin
                    state_d     = S_IDLE;
                    htrans_d    = HT_IDLE;
                    cnt_d       = '0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else if (hready_i) begin
                    cnt_d    = '0;
                    htrans_d = HT_IDLE;
                    if (state_q == S_ADDR) begin
                        state_d = S_DATA;
                    end else begin
                        state_d     = S_IDLE;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = hresp_i;
                        if (!hresp_i && !hwrite_q) begin
                            rsp_rdata_d = load_data;
                        end
                    end
                end else if (TO_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // Drop NONSEQ together with the count reaching its limit
                    if (cnt_q == TO_LAST) begin
                        htrans_d = HT_IDLE;
                    end
                end
            end
            default: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            haddr_q     <= '0;
            htrans_q    <= HT_IDLE;
            hwrite_q    <= 1'b0;
            hsize_q     <= '0;
            hwdata_q    <= '0;
            cnt_q       <= '0;
            unsigned_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            haddr_q     <= haddr_d;
            htrans_q    <= htrans_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            hwdata_q    <= hwdata_d;
            cnt_q       <= cnt_d;
            unsigned_q  <= unsigned_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_riscv_bus_master.sv
// Self-checking bench for riscv_bus_master (ADDR_W=32, DATA_W=32, TIMEOUT=16).
module tb_riscv_bus_master;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] haddr, hwdata, hrdata;
    logic [1:0]  htrans;
    logic        hwrite, hready, hresp;
    logic [2:0]  hsize;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    riscv_bus_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .haddr_o(haddr), .htrans_o(htrans), .hwrite_o(hwrite),
        .hsize_o(hsize), .hwdata_o(hwdata), .hrdata_i(hrdata), .hready_i(hready),
        .hresp_i(hresp)
    );

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] hrd;
        logic        resp;
        int          aw;
        int          dw;
        logic [31:0] e_rdata;
        logic        e_err;
        int          e_lat;
        logic [31:0] e_hw;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, " htrans"}, 64'(htrans), 64'd0);
        chk({nm, " haddr"}, 64'(haddr), 64'd0);
        chk({nm, " hwrite"}, 64'(hwrite), 64'd0);
        chk({nm, " hsize"}, 64'(hsize), 64'd0);
        chk({nm, " hwdata"}, 64'(hwdata), 64'd0);
        chk({nm, " rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({nm, " rsp_rdata"}, 64'(rsp_rdata), 64'd0);
        chk({nm, " rsp_err"}, 64'(rsp_err), 64'd0);
        chk({nm, " req_ready"}, 64'(req_ready), 64'd1);
    endtask

    // Reference: result, latency (cycles after the accepting edge) and bus write data
    function automatic void model(input logic wr, input logic [1:0] sz, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] hrd, input logic resp, input int aw,
                                  input int dw, output logic [31:0] rdata, output logic err,
                                  output int lat, output logic [31:0] hw);
        int nb;
        logic [31:0] v, m;
        nb = 1 << sz;
        case (nb)
            1:       hw = (wdata & 32'hFF) * 32'h0101_0101;
            2:       hw = (wdata & 32'hFFFF) * 32'h0001_0001;
            default: hw = wdata;
        endcase
        rdata = 32'h0;
        err   = 1'b0;
        if (sz == 2'd3 || (addr % nb) != 0) begin
            err = 1'b1;
            lat = 2;
        end else if (aw >= TO) begin
            err = 1'b1;
            lat = TO + 2;
        end else if (dw >= TO) begin
            err = 1'b1;
            lat = aw + TO + 3;
        end else begin
            lat = aw + dw + 3;
            err = resp;
            if (!resp && !wr) begin
                v = hrd >> (8 * (addr % 4));
                if (nb < 4) begin
                    m = (32'd1 << (8 * nb)) - 32'd1;
                    v = v & m;
                    if (!uns && v[8*nb-1]) v = v | ~m;
                end
                rdata = v;
            end
        end
    endfunction

    // One request from an idle cycle through its response; HREADY follows aw/dw wait counts
    task automatic run_txn(input string nm, input logic wr, input logic [1:0] sz,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] hrd, input logic resp, input int aw, input int dw,
                           input logic noise, input logic [31:0] e_rdata, input logic e_err,
                           input int e_lat, input logic [31:0] e_hw);
        int got;
        logic legal;
        legal = (e_lat > 2);
        got   = 0;
        chk({nm, " ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; hrdata = hrd; hready = 1'b1; hresp = 1'b0;
        @(negedge clk);
        for (int k = 1; k <= 60 && got == 0; k++) begin
            if (k == 1) begin
                chk({nm, " htrans_addr"}, 64'(htrans), legal ? 64'd2 : 64'd0);
                if (legal) begin
                    chk({nm, " haddr"}, 64'(haddr), 64'(addr));
                    chk({nm, " hwrite"}, 64'(hwrite), 64'(wr));
                    chk({nm, " hsize"}, 64'(hsize), 64'(sz));
                end
            end
            if (legal && aw < TO && k == aw + 2) begin
                chk({nm, " htrans_data"}, 64'(htrans), 64'd0);
                if (wr) chk({nm, " hwdata"}, 64'(hwdata), 64'(e_hw));
            end
            if (legal && aw < TO && dw > 0 && dw < TO && wr && k == aw + 2 + dw)
                chk({nm, " hwdata_held"}, 64'(hwdata), 64'(e_hw));
            if (legal && aw >= TO && k == TO + 1)
                chk({nm, " htrans_timeout"}, 64'(htrans), 64'd0);
            if (rsp_valid) begin
                got = k;
                chk({nm, " latency"}, 64'(got), 64'(e_lat));
                chk({nm, " rdata"}, 64'(rsp_rdata), 64'(e_rdata));
                chk({nm, " err"}, 64'(rsp_err), 64'(e_err));
                chk({nm, " ready_at_rsp"}, 64'(req_ready), 64'd1);
                req_valid = 1'b0; hready = 1'b1; hresp = 1'b0;
            end else begin
                if (k <= aw) hready = 1'b0;
                else if (k == aw + 1) hready = 1'b1;
                else if (k < aw + 2 + dw) hready = 1'b0;
                else hready = 1'b1;
                hresp = (legal && aw < TO && dw < TO && k == aw + 2 + dw) ? resp : 1'b0;
                req_valid = noise;
                if (noise) begin
                    req_write = 1'($urandom_range(0, 1));
                    req_size = 2'($urandom_range(0, 3));
                    req_unsigned = 1'($urandom_range(0, 1));
                    req_addr = $urandom();
                    req_wdata = $urandom();
                end
                @(negedge clk);
            end
        end
        if (got == 0) begin
            checks++;
            fails++;
            $display("FAIL %s no_response: got none expected rsp_valid at cycle %0d", nm, e_lat);
            req_valid = 1'b0; hready = 1'b1; hresp = 1'b0;
        end
    endtask

    vec_t tbl[17];

    initial begin
        logic [31:0] e_rd, e_hw, wd, ad, hd;
        logic        e_er, wr, un, rs;
        logic [1:0]  sz;
        int          e_lt, aw, dw;

        tbl[0]  = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 0,  0,  32'hDEADBEEF, 1'b0, 3,  32'h0};
        tbl[1]  = '{1'b0, 2'd0, 1'b0, 32'h103, 32'h0,        32'h80FF0000, 1'b0, 0,  0,  32'hFFFFFF80, 1'b0, 3,  32'h0};
        tbl[2]  = '{1'b0, 2'd0, 1'b1, 32'h103, 32'h0,        32'h80FF0000, 1'b0, 0,  0,  32'h00000080, 1'b0, 3,  32'h0};
        tbl[3]  = '{1'b1, 2'd1, 1'b0, 32'h202, 32'h1234,     32'h0,        1'b0, 0,  3,  32'h0,        1'b0, 6,  32'h12341234};
        tbl[4]  = '{1'b0, 2'd2, 1'b0, 32'h101, 32'h0,        32'h11111111, 1'b0, 0,  0,  32'h0,        1'b1, 2,  32'h0};
        tbl[5]  = '{1'b0, 2'd2, 1'b0, 32'h200, 32'h0,        32'h12345678, 1'b1, 0,  0,  32'h0,        1'b1, 3,  32'h0};
        tbl[6]  = '{1'b0, 2'd2, 1'b0, 32'h300, 32'h0,        32'h12345678, 1'b0, 16, 0,  32'h0,        1'b1, 18, 32'h0};
        tbl[7]  = '{1'b0, 2'd1, 1'b0, 32'h102, 32'h0,        32'h80017FFF, 1'b0, 2,  0,  32'hFFFF8001, 1'b0, 5,  32'h0};
        tbl[8]  = '{1'b0, 2'd1, 1'b0, 32'h103, 32'h0,        32'h0,        1'b0, 0,  0,  32'h0,        1'b1, 2,  32'h0};
        tbl[9]  = '{1'b0, 2'd3, 1'b0, 32'h000, 32'h0,        32'h0,        1'b0, 0,  0,  32'h0,        1'b1, 2,  32'h0};
        tbl[10] = '{1'b1, 2'd0, 1'b0, 32'h005, 32'hFFFFFFA5, 32'h0,        1'b0, 1,  1,  32'h0,        1'b0, 5,  32'hA5A5A5A5};
        tbl[11] = '{1'b0, 2'd2, 1'b0, 32'h400, 32'h0,        32'h12345678, 1'b0, 0,  16, 32'h0,        1'b1, 19, 32'h0};
        tbl[12] = '{1'b0, 2'd2, 1'b0, 32'h500, 32'h0,        32'hCAFEF00D, 1'b0, 15, 0,  32'hCAFEF00D, 1'b0, 18, 32'h0};
        tbl[13] = '{1'b0, 2'd0, 1'b1, 32'h002, 32'h0,        32'h12345678, 1'b0, 0,  0,  32'h00000034, 1'b0, 3,  32'h0};
        tbl[14] = '{1'b1, 2'd2, 1'b0, 32'h010, 32'h89ABCDEF, 32'h0,        1'b1, 0,  0,  32'h0,        1'b1, 3,  32'h89ABCDEF};
        tbl[15] = '{1'b0, 2'd1, 1'b1, 32'h000, 32'h0,        32'h1234F00D, 1'b0, 0,  0,  32'h0000F00D, 1'b0, 3,  32'h0};
        tbl[16] = '{1'b0, 2'd1, 1'b0, 32'h002, 32'h0,        32'hF00D1234, 1'b0, 0,  15, 32'hFFFFF00D, 1'b0, 18, 32'h0};

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; hrdata = 32'h0; hready = 1'b1; hresp = 1'b0;
        @(negedge clk);
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 17; i++)
            run_txn($sformatf("vec%0d", i), tbl[i].wr, tbl[i].sz, tbl[i].uns, tbl[i].addr,
                    tbl[i].wdata, tbl[i].hrd, tbl[i].resp, tbl[i].aw, tbl[i].dw, 1'b0,
                    tbl[i].e_rdata, tbl[i].e_err, tbl[i].e_lat, tbl[i].e_hw);

        // Reset asserted while a store sits in its data phase
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 32'h40;
        req_wdata = 32'h11223344; hready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("midrst htrans_before", 64'(htrans), 64'd2);
        @(negedge clk);
        hready = 1'b0;
        chk("midrst hwdata_before", 64'(hwdata), 64'h11223344);
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        hready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("postrst rsp_valid%0d", i), 64'(rsp_valid), 64'd0);
            chk($sformatf("postrst ready%0d", i), 64'(req_ready), 64'd1);
        end

        // Randomized traffic, back-to-back, with request noise during busy cycles
        for (int i = 0; i < 200; i++) begin
            wr = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            un = 1'($urandom_range(0, 1));
            ad = $urandom();
            if ($urandom_range(0, 3) != 0) ad = ad & ~((32'd1 << sz) - 32'd1);
            wd = $urandom();
            hd = $urandom();
            rs = ($urandom_range(0, 7) == 0);
            aw = ($urandom_range(0, 19) == 0) ? int'($urandom_range(14, 18)) : int'($urandom_range(0, 3));
            dw = ($urandom_range(0, 19) == 0) ? int'($urandom_range(14, 18)) : int'($urandom_range(0, 3));
            model(wr, sz, un, ad, wd, hd, rs, aw, dw, e_rd, e_er, e_lt, e_hw);
            run_txn($sformatf("rnd%0d", i), wr, sz, un, ad, wd, hd, rs, aw, dw,
                    1'($urandom_range(0, 1)), e_rd, e_er, e_lt, e_hw);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
